// File: rtl/rr_bus_arbiter_pkg.sv
// arb_pkg: shared state encoding, transfer-size codes and helpers for the
// round-robin X bus arbiter and its rotating priority encoder.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    localparam logic [1:0] SIZ_BYTE  = 2'd0;
    localparam logic [1:0] SIZ_HALF  = 2'd1;
    localparam logic [1:0] SIZ_WORD  = 2'd2;
    localparam logic [1:0] SIZ_DWORD = 2'd3;

    // Binary index of the set bit in a one-hot vector of up to eight masters.
    function automatic int unsigned onehot_to_index(input logic [7:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_pick.sv
// rr_pick: combinational rotating priority encoder. Searches the request
// vector starting just after the previous owner and wrapping modulo NM.
module rr_pick #(
    parameter int NM = 2,
    parameter int IW = 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [IW-1:0] last_i,
    output logic [NM-1:0] gnt_o,
    output logic          valid_o
);

    // First requester at distance 1, 2, ... NM from the previous owner wins
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int off = 1; off <= NM; off++) begin
            for (int j = 0; j < NM; j++) begin
                if (!valid_o && req_i[j] && (j == ((int'(last_i) + off) % NM))) begin
                    gnt_o[j] = 1'b1;
                    valid_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: funnels NM bus masters onto one X bus slave port using a
// registered round-robin grant that stays locked for the owner's whole cyc.
// Optional watchdog: define RR_BUS_ARBITER_TIMEOUT_EN to enable the stalled
// transfer timeout (TIMEOUT_CYCLES); otherwise m_err_o is tied low.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int NM             = 2,
    parameter int AW             = 64,
    parameter int DW             = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [2*NM-1:0]  m_siz_i,
    input  logic [NM-1:0]    m_signed_i,
    input  logic [AW*NM-1:0] m_adr_i,
    input  logic [DW*NM-1:0] m_dat_i,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [DW-1:0]    m_dat_o,
    output logic [NM-1:0]    gnt_o,
    output logic             x_cyc_o,
    output logic             x_stb_o,
    output logic             x_we_o,
    output logic [1:0]       x_siz_o,
    output logic             x_signed_o,
    output logic [AW-1:0]    x_adr_o,
    output logic [DW-1:0]    x_dat_o,
    input  logic             x_ack_i,
    input  logic [DW-1:0]    x_dat_i
);

    localparam int IW = $clog2(NM);

    arb_state_e    state_q, state_d;
    logic [NM-1:0] gnt_q, gnt_d;
    logic [IW-1:0] last_q, last_d;
    logic [NM-1:0] req_eff;
    logic [NM-1:0] pick_gnt;
    logic          pick_valid;
    logic          owner_cyc;
    logic          tmo_fire;

    rr_pick #(
        .NM (NM),
        .IW (IW)
    ) u_pick (
        .req_i   (req_eff),
        .last_i  (last_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

`ifdef RR_BUS_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [NM-1:0] tmo_mask_q, tmo_mask_d;

    assign tmo_fire = (state_q == ST_OWNED) && x_stb_o && !x_ack_i &&
                      (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign req_eff  = m_cyc_i & ~tmo_mask_q;
    assign m_err_o  = tmo_fire ? gnt_q : '0;

    // Count unacked strobe cycles; a timed-out master is masked until it drops cyc
    always_comb begin
        tmo_cnt_d  = tmo_cnt_q;
        tmo_mask_d = (tmo_mask_q | (tmo_fire ? gnt_q : '0)) & m_cyc_i;
        if (state_q == ST_IDLE) begin
            if (pick_valid) begin
                tmo_cnt_d = '0;
            end
        end else if (x_ack_i) begin
            tmo_cnt_d = '0;
        end else if (x_stb_o) begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
    end

    // Watchdog registers
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            tmo_cnt_q  <= '0;
            tmo_mask_q <= '0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_mask_q <= tmo_mask_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign req_eff  = m_cyc_i;
    assign m_err_o  = '0;
`endif

    assign gnt_o   = gnt_q;
    assign m_dat_o = x_dat_i;

    // Route the owner's request fields to the slave and the slave ack back to it
    always_comb begin
        owner_cyc  = 1'b0;
        x_stb_o    = 1'b0;
        x_we_o     = 1'b0;
        x_siz_o    = '0;
        x_signed_o = 1'b0;
        x_adr_o    = '0;
        x_dat_o    = '0;
        m_ack_o    = '0;
        if (state_q == ST_OWNED) begin
            for (int i = 0; i < NM; i++) begin
                if (gnt_q[i]) begin
                    owner_cyc  = m_cyc_i[i];
                    x_stb_o    = m_stb_i[i];
                    x_we_o     = m_we_i[i];
                    x_siz_o    = m_siz_i[2*i +: 2];
                    x_signed_o = m_signed_i[i];
                    x_adr_o    = m_adr_i[AW*i +: AW];
                    x_dat_o    = m_dat_i[DW*i +: DW];
                    m_ack_o[i] = x_ack_i;
                end
            end
        end
        x_cyc_o = owner_cyc;
    end

    // Grant in IDLE, hold while the owner keeps cyc, release through one IDLE cycle
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    gnt_d   = pick_gnt;
                    state_d = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (!owner_cyc || tmo_fire) begin
                    gnt_d   = '0;
                    last_d  = IW'(onehot_to_index(8'(gnt_q)));
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbitration state registers; last owner resets to NM-1 so master 0 goes first
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NM - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Parametrised N-master successor to the two-port I/D arbiter that funnels CPU instruction and data ports onto the single X bus.
- Arbitrates NM requesters onto one slave port using registered round-robin grants, with bus locking held for the duration of each master's cyc.
- Sits between the PolarisCPU ports (plus any DMA/debug masters) and the bridge/address-decode fabric.

Parameters:
- NM, 2, number of masters (2..8).
- AW, 64, address width.
- DW, 64, data width.
- TIMEOUT_CYCLES, 255, watchdog limit. Used only when the optional feature is enabled.

Ports:
- clk_i  in  1  sole clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-low reset.
- m_cyc_i  in  NM  per-master cycle (bus request/lock).
- m_stb_i  in  NM  per-master strobe.
- m_we_i  in  NM  per-master write enable.
- m_siz_i  in  2*NM  per-master transfer size (0=byte, 1=half, 2=word, 3=dword).
- m_signed_i  in  NM  per-master sign-extend request.
- m_adr_i  in  AW*NM  per-master address; slice k is master k.
- m_dat_i  in  DW*NM  per-master write data.
- m_ack_o  out  NM  per-master acknowledge.
- m_err_o  out  NM  per-master timeout error.
- m_dat_o  out  DW  read data, broadcast to all masters.
- gnt_o  out  NM  one-hot registered grant.
- x_cyc_o  out  1  slave cycle.
- x_stb_o  out  1  slave strobe.
- x_we_o  out  1  slave write enable.
- x_siz_o  out  2  slave transfer size.
- x_signed_o  out  1  slave sign-extend.
- x_adr_o  out  AW  slave address.
- x_dat_o  out  DW  slave write data.
- x_ack_i  in  1  slave acknowledge.
- x_dat_i  in  DW  slave read data.

Behaviour:
- Reset (reset_i=0 at an edge):
  - state=IDLE, gnt_o=0, last-owner pointer=NM-1, so master 0 has first priority.
  - All x_* outputs, m_ack_o and m_err_o read 0.
  - Reset mid-transaction drops the grant at that edge. Any x_ack_i in later cycles is discarded.
- IDLE:
  - gnt_o=0 and x_* outputs=0.
  - If any m_cyc_i is set: choose the first requester searching last+1, last+2, … modulo NM; load gnt_o one-hot; go to OWNED.
  - Grant latency: a request in cycle 0 gives gnt_o and x_cyc_o in cycle 1.
- OWNED, owner k:
  - x_cyc_o=m_cyc_i[k].
  - x_stb_o, x_we_o, x_siz_o, x_signed_o, x_adr_o and x_dat_o are combinational muxes of master k's slice.
  - m_ack_o[k]=x_ack_i, combinational. Every other m_ack_o bit is 0.
  - m_dat_o=x_dat_i at all times.
- Release: when m_cyc_i[k]=0 at an edge, go to IDLE and set last=k.
  - There is always one idle turnaround cycle between owners, even if requests are pending.
  - A single master re-requesting is regranted after that IDLE cycle.
- Fairness: with all NM masters requesting continuously and each releasing after one transfer, grants rotate 0,1,…,NM-1,0. No master waits more than NM-1 tenures.
- Multiple transfers per tenure: the owner may pulse stb many times within one cyc. The arbiter does not count transfers.
- Boundary cases:
  - x_ack_i while IDLE: ignored.
  - Owner dropping cyc in the same cycle ack arrives: the ack is still delivered and release happens at that edge.
  - m_stb_i without m_cyc_i: never granted.
- Width rules: slice k of m_adr_i is bits [AW*k+AW-1 : AW*k]; the same pattern applies to m_dat_i and m_siz_i.

Optional Feature:
- Macro: RR_BUS_ARBITER_TIMEOUT_EN.
- With the macro:
  - A counter clears on grant and on every x_ack_i, and increments each OWNED cycle in which x_stb_o=1 and x_ack_i=0.
  - When the counter reaches TIMEOUT_CYCLES: m_err_o[k] pulses for exactly one cycle, the grant is forcibly released to IDLE, and last=k.
  - The master must drop cyc. Until it does, it is not rearbitrated ahead of other requesters.
- Without the macro: m_err_o is tied to 0, no counter exists, and TIMEOUT_CYCLES is ignored.

Decomposition:
- Package arb_pkg holds:
  - state enum {ST_IDLE, ST_OWNED};
  - size constants SIZ_BYTE/HALF/WORD/DWORD;
  - function onehot_to_index.
- One natural sub-module: rr_pick, a combinational rotating priority encoder. Inputs are req[NM] and last index; outputs are grant one-hot and valid.

Test Plan:
- Reset: hold reset_i=0 for 3 cycles with m_cyc_i=2'b11 -> gnt_o=0, x_cyc_o=0, m_ack_o=0 throughout; after release, gnt_o=2'b01 one cycle later.
- Latency/passthrough, NM=2: master1 alone drives cyc/stb, adr=0x1008, siz=3, we=0, and slave acks with x_dat_i=0xDEADBEEF -> gnt_o=2'b10 one cycle after request; x_adr_o=0x1008; m_ack_o=2'b10; m_dat_o=0xDEADBEEF.
- Round-robin, NM=4: all four hold cyc, each releasing after one ack -> grant order 0,1,2,3,0 with one IDLE cycle between tenures.
- Lock: master0 holds cyc across 3 stb/ack transfers while master1 requests -> master1 is not granted until master0 drops cyc, then is granted after one IDLE cycle.
- Mid-transaction reset: reset_i=0 asserted while owner stb is pending -> gnt_o=0 at that edge; a late x_ack_i produces no m_ack_o.
- Timeout, macro set with TIMEOUT_CYCLES=8: owner strobes and slave never acks -> m_err_o pulses for one cycle on the 8th unacked cycle; gnt_o=0 on the following cycle.
